uart_rx_baud_sampler: RTL and testbench



---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_rx_sync.sv | 61 ++++++
 rtl/uart_rx_baud_sampler.sv | 126 ++++++++++++
 tb/tb_uart_rx_baud_sampler.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: receiver state encoding and
// the default oversample ratio.
package uart_pkg;

    localparam int OVERSAMPLE_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        ARMED = 2'd2,
        RUN   = 2'd3
    } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// RxD two-flop synchroniser producing rx_s and the decision value rx_v.
// Build option: UART_RX_MAJORITY_EN makes rx_v a 3-sample majority vote.
module uart_rx_sync (
    input  logic Clock,
    input  logic Reset,
    input  logic SampleEn,
    input  logic RxD,
    output logic rx_s,
    output logic rx_v
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = RxD;
        sync_d = meta_q;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign rx_s = sync_q;

`ifdef UART_RX_MAJORITY_EN
    // Window = two previous enabled samples plus the current one, so the vote
    // reacts in the same cycle as the raw sample would.
    logic [1:0] hist_q, hist_d;
    logic [2:0] window;

    always_comb begin
        window = {hist_q, sync_q};
        hist_d = hist_q;
        if (SampleEn) begin
            hist_d = window[1:0];
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            hist_q <= 2'b11;
        end else begin
            hist_q <= hist_d;
        end
    end

    assign rx_v = (window[0] & window[1]) | (window[0] & window[2]) | (window[1] & window[2]);
`else
    logic sample_en_unused;
    assign sample_en_unused = SampleEn;
    assign rx_v = sync_q;
`endif

endmodule

// File: rtl/uart_rx_baud_sampler.sv
// Receive-side baud sampler: validates the start bit at its midpoint and ticks at every bit centre.
// Build option: UART_RX_MAJORITY_EN (majority-voted decision value inside uart_rx_sync).
module uart_rx_baud_sampler
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
    input  logic Clock,
    input  logic Reset,
    input  logic SampleEn,
    input  logic RxD,
    input  logic Shift,
    input  logic Idle,
    output logic StartDetect,
    output logic BitTick,
    output logic SampleBit,
    output logic FalseStart,
    output logic BaudClock
);
    // state | meaning
    // IDLE  | hunting for a low rx_s sample
    // START | counting low samples toward the start-bit midpoint
    // ARMED | start confirmed, waiting for Shift
    // RUN   | controller shifting, ticks at each bit centre until Idle

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int HALF = OVERSAMPLE / 2;
    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
    localparam logic [CW-1:0] HALF_C  = CW'(HALF);
    localparam logic [CW-1:0] LAST    = CW'(OVERSAMPLE - 1);

    rx_state_e       state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic            tick_q, tick_d;
    logic            sample_q, sample_d;
    logic            false_start_q, false_start_d;
    logic            rx_s, rx_v;

    uart_rx_sync u_sync (
        .Clock    (Clock),
        .Reset    (Reset),
        .SampleEn (SampleEn),
        .RxD      (RxD),
        .rx_s     (rx_s),
        .rx_v     (rx_v)
    );

    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        tick_d        = 1'b0;
        sample_d      = sample_q;
        false_start_d = 1'b0;
        case (state_q)
            IDLE: begin
                count_d = '0;
                if (SampleEn && !rx_s) begin
                    state_d = START;
                    count_d = CW'(1);
                end
            end
            START: begin
                if (SampleEn) begin
                    if (rx_v) begin
                        false_start_d = 1'b1;
                        state_d       = IDLE;
                        count_d       = '0;
                    end else if (count_q == HALF_M1) begin
                        state_d = ARMED;
                        count_d = '0;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            ARMED, RUN: begin
                if (SampleEn) begin
                    if (count_q == LAST) begin
                        count_d  = '0;
                        tick_d   = 1'b1;
                        sample_d = rx_v;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
                if (state_q == ARMED && Shift) begin
                    state_d = RUN;
                end
                // Idle beats a coincident tick: the frame is over.
                if (state_q == RUN && Idle) begin
                    state_d  = IDLE;
                    count_d  = '0;
                    tick_d   = 1'b0;
                    sample_d = sample_q;
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q       <= IDLE;
            count_q       <= '0;
            tick_q        <= 1'b0;
            sample_q      <= 1'b0;
            false_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            tick_q        <= tick_d;
            sample_q      <= sample_d;
            false_start_q <= false_start_d;
        end
    end

    assign StartDetect = (state_q == ARMED);
    assign BitTick     = tick_q;
    assign SampleBit   = sample_q;
    assign FalseStart  = false_start_q;
    assign BaudClock   = ((state_q == ARMED) || (state_q == RUN)) && (count_q >= HALF_C);

endmodule

// File: tb/tb_uart_rx_baud_sampler.sv
// Bench for uart_rx_baud_sampler: random frames checked against a timeline model
// derived from the sampling rules (sample counts, tick edges, decision values).
module tb_uart_rx_baud_sampler;

    localparam int OVS  = 16;
    localparam int HALF = OVS / 2;
    localparam int MAXN = 2048;
`ifdef UART_RX_MAJORITY_EN
    localparam int GLITCH_FS = 0;
`else
    localparam int GLITCH_FS = 1;
`endif

    logic Clock = 1'b0;
    logic Reset, SampleEn, RxD, Shift, Idle;
    logic StartDetect, BitTick, SampleBit, FalseStart, BaudClock;

    always #5 Clock = ~Clock;

    uart_rx_baud_sampler #(.OVERSAMPLE(OVS)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .SampleEn    (SampleEn),
        .RxD         (RxD),
        .Shift       (Shift),
        .Idle        (Idle),
        .StartDetect (StartDetect),
        .BitTick     (BitTick),
        .SampleBit   (SampleBit),
        .FalseStart  (FalseStart),
        .BaudClock   (BaudClock)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Stimulus and expectations indexed by clock edge number within a scenario.
    bit rxd_a  [0:MAXN];
    bit en_a   [0:MAXN];
    bit sh_a   [0:MAXN];
    bit id_a   [0:MAXN];
    bit x_sd   [0:MAXN];
    bit x_tick [0:MAXN];
    bit x_bit  [0:MAXN];
    bit x_fs   [0:MAXN];
    bit x_baud [0:MAXN];
    int scn_len;
    int p_cur;
    int frame_cnt = 0;
    int first_t [10];
    bit first_done;
    int fs_seen;
    bit obs_bits [$];
    int tick_edges [$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic overrun(input string where);
        $display("FAIL model_overrun %s: got edge>%0d expected within scenario", where, scn_len);
        $fatal(1, "scenario too short");
    endtask

    // Synchronised line value seen by the DUT at edge n.
    function automatic bit rs(input int n);
        return (n >= 3) ? rxd_a[n-2] : 1'b1;
    endfunction

    // Decision value at enabled edge n.
    function automatic bit rv(input int n);
`ifdef UART_RX_MAJORITY_EN
        int cnt  = 0;
        int ones = 0;
        for (int m = n; m >= 1 && cnt < 3; m--) begin
            if (en_a[m]) begin
                cnt++;
                ones += int'(rs(m));
            end
        end
        ones += 3 - cnt;
        return ones >= 2;
`else
        return rs(n);
`endif
    endfunction

    task automatic clear_scn(input int len, input int p);
        scn_len = len;
        p_cur = p;
        first_done = 0;
        for (int n = 0; n <= MAXN; n++) begin
            rxd_a[n] = 1'b1;
            en_a[n]  = (n % p == 0);
            sh_a[n]  = 1'b0;
            id_a[n]  = 1'b0;
            x_sd[n]  = 1'b0;
            x_tick[n] = 1'b0;
            x_bit[n] = 1'b0;
            x_fs[n]  = 1'b0;
            x_baud[n] = 1'b0;
        end
    endtask

    task automatic put_frame(input int f, input logic [7:0] data);
        int b = OVS * p_cur;
        for (int n = f; n < f + b; n++) rxd_a[n] = 1'b0;
        for (int i = 0; i < 8; i++)
            for (int n = f + (i+1)*b; n < f + (i+2)*b; n++) rxd_a[n] = data[i];
    endtask

    task automatic put_low(input int f, input int len);
        for (int n = f; n < f + len; n++) rxd_a[n] = 1'b0;
    endtask

    // Walk the line timeline: hunt, confirm after HALF low samples, tick every OVS samples.
    task automatic build_expect();
        int n, m, got, c, d, ie, ecnt, nt;
        bit aborted;
        int tk [10];
        n = 1;
        while (n <= scn_len) begin
            if (!en_a[n] || rs(n)) begin
                n++;
            end else begin
                m = n; got = 1; aborted = 0;
                while (got < HALF) begin
                    m++;
                    if (m > scn_len) overrun("start");
                    if (en_a[m]) begin
                        if (rv(m)) begin
                            x_fs[m] = 1'b1; aborted = 1; got = HALF;
                        end else got++;
                    end
                end
                if (aborted) begin
                    n = m + 1;
                end else begin
                    c = m;
                    d = int'($urandom_range(1, 5));
                    sh_a[c+d] = 1'b1;
                    for (int k = c; k < c + d; k++) x_sd[k] = 1'b1;
                    ecnt = 0; nt = 0; m = c;
                    while (nt < 9) begin
                        m++;
                        if (m > scn_len) overrun("ticks");
                        if (en_a[m]) begin
                            ecnt++;
                            if (ecnt % OVS == 0) begin nt++; tk[nt] = m; end
                        end
                    end
                    if (frame_cnt % 2 == 0) ie = tk[9];
                    else ie = tk[8] + int'($urandom_range(1, tk[9] - tk[8] - 1));
                    frame_cnt++;
                    id_a[ie] = 1'b1;
                    ecnt = 0;
                    for (int t = c; t < ie; t++) begin
                        if (t > c && en_a[t]) begin
                            ecnt++;
                            if (ecnt % OVS == 0) begin x_tick[t] = 1'b1; x_bit[t] = rv(t); end
                        end
                        x_baud[t] = (ecnt % OVS) >= HALF;
                    end
                    if (!first_done) begin first_t = tk; first_done = 1; end
                    n = ie + 1;
                end
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, " StartDetect"}, StartDetect, 0);
        check_val({tag, " BitTick"}, BitTick, 0);
        check_val({tag, " SampleBit"}, SampleBit, 0);
        check_val({tag, " FalseStart"}, FalseStart, 0);
        check_val({tag, " BaudClock"}, BaudClock, 0);
    endtask

    task automatic run_scn(input string name, input int abort_at);
        fs_seen = 0;
        obs_bits.delete();
        tick_edges.delete();
        for (int n = 1; n <= scn_len; n++) begin
            RxD = rxd_a[n]; SampleEn = en_a[n]; Shift = sh_a[n]; Idle = id_a[n];
            Reset = (n == abort_at);
            @(posedge Clock);
            @(negedge Clock);
            if (n == abort_at) begin
                check_all_zero($sformatf("%s reset@%0d", name, n));
                Reset = 1'b0;
                break;
            end
            check_val($sformatf("%s StartDetect@%0d", name, n), StartDetect, x_sd[n]);
            check_val($sformatf("%s BitTick@%0d", name, n), BitTick, x_tick[n]);
            check_val($sformatf("%s FalseStart@%0d", name, n), FalseStart, x_fs[n]);
            check_val($sformatf("%s BaudClock@%0d", name, n), BaudClock, x_baud[n]);
            if (x_tick[n]) check_val($sformatf("%s SampleBit@%0d", name, n), SampleBit, x_bit[n]);
            if (FalseStart === 1'b1) fs_seen++;
            if (BitTick === 1'b1) begin
                obs_bits.push_back(SampleBit);
                tick_edges.push_back(n);
            end
        end
    endtask

    task automatic do_reset();
        Reset = 1'b1; RxD = 1'b1; SampleEn = 1'b1; Shift = 1'b0; Idle = 1'b0;
        repeat (2) begin @(posedge Clock); @(negedge Clock); end
        Reset = 1'b0;
    endtask

    initial begin
        logic [7:0] byte0;
        Reset = 1'b1; RxD = 1'b0; SampleEn = 1'b1; Shift = 1'b0; Idle = 1'b0;
        @(negedge Clock);
        for (int i = 0; i < 3; i++) begin
            @(posedge Clock);
            @(negedge Clock);
            check_all_zero($sformatf("hold_reset%0d", i));
        end

        // SampleEn every clock: 0x55, a short false start, random frames.
        do_reset();
        clear_scn(760, 1);
        put_frame(5, 8'h55);
        put_low(185, 3);
        put_frame(220, 8'($urandom));
        put_frame(400, 8'($urandom));
        put_frame(580, 8'($urandom));
        build_expect();
        run_scn("p1", 0);
        check_val("p1 false_start_count", fs_seen, 1);
        byte0 = '0;
        for (int i = 0; i < 8; i++) if (i < obs_bits.size()) byte0[i] = obs_bits[i];
        check_val("p1 first_byte", byte0, 8'h55);
        check_val("p1 tick_period", (tick_edges.size() > 1) ? tick_edges[1] - tick_edges[0] : 0, OVS);

        // One-clock high glitch landing on START sample 4.
        do_reset();
        clear_scn(200, 1);
        put_frame(5, 8'($urandom));
        rxd_a[8] = 1'b1;
        build_expect();
        run_scn("glitch", 0);
        check_val("glitch false_start_count", fs_seen, GLITCH_FS);

        // SampleEn every 4th clock.
        do_reset();
        clear_scn(1400, 4);
        put_frame(8, 8'($urandom));
        put_frame(688, 8'($urandom));
        build_expect();
        run_scn("p4", 0);
        check_val("p4 tick_period", (tick_edges.size() > 1) ? tick_edges[1] - tick_edges[0] : 0, OVS * 4);

        // Reset landing on a tick edge mid-RUN.
        do_reset();
        clear_scn(700, 4);
        put_frame(8, 8'($urandom));
        build_expect();
        run_scn("abort", first_t[3]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
